mandelbrot_iterator: RTL and testbench

- Per-pixel iteration controller that drives the team's single-step Mandelbrot ALU (z' = z² + c, with start/finished handshake).
- Accepts one complex point c per transaction and seeds z = 0.
- Repeatedly starts the ALU, feeding each result back as the next z, until escape (size or overflow flag) or the iteration limit.
- Returns the iteration count and an escaped flag over a valid/ready handshake. Sits between the pixel/coordinate generator and the colour mapper.

---
 rtl/mandelbrot_iterator_if.sv | 44 ++++
 rtl/mandelbrot_iterator.sv | 139 +++++++++++++
 tb/tb_mandelbrot_iterator.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mandelbrot_iterator_if.sv
// Bundle between the Mandelbrot iteration controller and its environment.
// It carries the pixel handshake, the result handshake and the single-step
// ALU bus. The controller takes the slave view; the environment (pixel
// generator, colour mapper and ALU together) takes the master view.
interface mandelbrot_iterator_if #(
  parameter int WIDTH      = 8,
  parameter int ITER_WIDTH = 8
);
  logic                  pixel_valid;
  logic                  pixel_ready;
  logic [WIDTH-1:0]      cr;
  logic [WIDTH-1:0]      ci;
  logic [ITER_WIDTH-1:0] max_iter;

  logic                  result_valid;
  logic                  result_ready;
  logic [ITER_WIDTH-1:0] result_iter;
  logic                  result_escaped;

  logic                  alu_start;
  logic                  alu_finished;
  logic [WIDTH-1:0]      alu_cr;
  logic [WIDTH-1:0]      alu_ci;
  logic [WIDTH-1:0]      alu_zr;
  logic [WIDTH-1:0]      alu_zi;
  logic [WIDTH-1:0]      alu_zr_next;
  logic [WIDTH-1:0]      alu_zi_next;
  logic                  alu_size;
  logic                  alu_overflow;

  modport master (
    output pixel_valid, cr, ci, max_iter, result_ready,
           alu_finished, alu_zr_next, alu_zi_next, alu_size, alu_overflow,
    input  pixel_ready, result_valid, result_iter, result_escaped,
           alu_start, alu_cr, alu_ci, alu_zr, alu_zi
  );

  modport slave (
    input  pixel_valid, cr, ci, max_iter, result_ready,
           alu_finished, alu_zr_next, alu_zi_next, alu_size, alu_overflow,
    output pixel_ready, result_valid, result_iter, result_escaped,
           alu_start, alu_cr, alu_ci, alu_zr, alu_zi
  );
endinterface

// File: rtl/mandelbrot_iterator.sv
// Per-pixel Mandelbrot iteration controller. Takes one point c, seeds z = 0,
// and repeatedly starts the single-step ALU (z' = z^2 + c), feeding each
// result back as the next z. It stops on escape (size or overflow) or when
// the iteration limit is reached, then returns the count and an escaped flag.
module mandelbrot_iterator #(
  parameter int WIDTH      = 8,
  parameter int ITER_WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  mandelbrot_iterator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_t;

  state_t                state, state_n;
  logic [WIDTH-1:0]      c_r, c_i, z_r, z_i;
  logic [WIDTH-1:0]      c_r_n, c_i_n, z_r_n, z_i_n;
  logic [ITER_WIDTH-1:0] limit, limit_n;
  logic [ITER_WIDTH-1:0] iter, iter_n, iter_inc;
  logic [ITER_WIDTH-1:0] res_iter, res_iter_n;
  logic                  res_esc, res_esc_n;
  logic                  pixel_ready_q, result_valid_q, alu_start_q;

  // iter < limit always holds here, so this never wraps
  assign iter_inc = iter + 1'b1;

  // Next-state and next-datapath decode; every register holds by default
  always_comb begin
    state_n    = state;
    c_r_n      = c_r;
    c_i_n      = c_i;
    z_r_n      = z_r;
    z_i_n      = z_i;
    limit_n    = limit;
    iter_n     = iter;
    res_iter_n = res_iter;
    res_esc_n  = res_esc;
    case (state)
      IDLE: begin
        if (bus.pixel_valid) begin
          c_r_n   = bus.cr;
          c_i_n   = bus.ci;
          limit_n = bus.max_iter;
          z_r_n   = '0;
          z_i_n   = '0;
          iter_n  = '0;
          if (bus.max_iter == '0) begin
            state_n    = DONE;
            res_iter_n = '0;
            res_esc_n  = 1'b0;
          end else begin
            state_n = START;
          end
        end
      end
      START: begin
        state_n = WAIT;
      end
      WAIT: begin
        if (bus.alu_finished) begin
          if (bus.alu_size | bus.alu_overflow) begin
            // escaping step: report its index, keep the last good z
            state_n    = DONE;
            res_iter_n = iter;
            res_esc_n  = 1'b1;
          end else begin
            z_r_n  = bus.alu_zr_next;
            z_i_n  = bus.alu_zi_next;
            iter_n = iter_inc;
            if (iter_inc == limit) begin
              state_n    = DONE;
              res_iter_n = limit;
              res_esc_n  = 1'b0;
            end else begin
              state_n = START;
            end
          end
        end
      end
      DONE: begin
        if (bus.result_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      c_r            <= '0;
      c_i            <= '0;
      z_r            <= '0;
      z_i            <= '0;
      limit          <= '0;
      iter           <= '0;
      res_iter       <= '0;
      res_esc        <= 1'b0;
      pixel_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
      alu_start_q    <= 1'b0;
    end else begin
      state          <= state_n;
      c_r            <= c_r_n;
      c_i            <= c_i_n;
      z_r            <= z_r_n;
      z_i            <= z_i_n;
      limit          <= limit_n;
      iter           <= iter_n;
      res_iter       <= res_iter_n;
      res_esc        <= res_esc_n;
      // outputs are registered copies of the decoded next state
      pixel_ready_q  <= (state_n == IDLE);
      result_valid_q <= (state_n == DONE);
      alu_start_q    <= (state_n == START);
    end
  end

  assign bus.pixel_ready    = pixel_ready_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.result_iter    = res_iter;
  assign bus.result_escaped = res_esc;
  assign bus.alu_start      = alu_start_q;
  assign bus.alu_cr         = c_r;
  assign bus.alu_ci         = c_i;
  assign bus.alu_zr         = z_r;
  assign bus.alu_zi         = z_i;

endmodule

// File: tb/tb_mandelbrot_iterator.sv
// Bench for mandelbrot_iterator: behavioural 2.6 fixed-point ALU with
// configurable latency, table of points with known outcomes, scoreboard of
// expected results, and hand sequences for reset, backpressure and limits.
module tb_mandelbrot_iterator;
  localparam int W  = 8;
  localparam int IW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mandelbrot_iterator_if #(.WIDTH(W), .ITER_WIDTH(IW)) bus ();

  mandelbrot_iterator #(.WIDTH(W), .ITER_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- ALU model ----------------
  int   lat       = 1;
  logic never_esc = 1'b0;
  int   cnt       = 0;
  logic [17:0] step_r;

  // one step z' = z^2 + c in 2.6 format; returns {zr', zi', size, overflow}
  function automatic logic [17:0] alu_model(input logic signed [7:0] zr,
                                             input logic signed [7:0] zi,
                                             input logic signed [7:0] cr,
                                             input logic signed [7:0] ci);
    int sr, si, mag;
    logic signed [7:0] nr, ni;
    logic ov, sz;
    sr  = ((int'(zr) * int'(zr) - int'(zi) * int'(zi)) >>> 6) + int'(cr);
    si  = ((2 * int'(zr) * int'(zi)) >>> 6) + int'(ci);
    ov  = (sr > 127) || (sr < -128) || (si > 127) || (si < -128);
    nr  = sr[7:0];
    ni  = si[7:0];
    mag = (int'(nr) * int'(nr) + int'(ni) * int'(ni)) >>> 6;
    sz  = (mag > 256);
    return {nr, ni, sz, ov};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt              <= 0;
      bus.alu_finished <= 1'b0;
      bus.alu_zr_next  <= '0;
      bus.alu_zi_next  <= '0;
      bus.alu_size     <= 1'b0;
      bus.alu_overflow <= 1'b0;
    end else begin
      bus.alu_finished <= 1'b0;
      if (bus.alu_start) begin
        step_r = alu_model(bus.alu_zr, bus.alu_zi, bus.alu_cr, bus.alu_ci);
        bus.alu_zr_next  <= step_r[17:10];
        bus.alu_zi_next  <= step_r[9:2];
        bus.alu_size     <= step_r[1] & ~never_esc;
        bus.alu_overflow <= step_r[0] & ~never_esc;
        cnt <= lat;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) bus.alu_finished <= 1'b1;
      end
    end
  end

  // ---------------- monitors (negedge sampling) ----------------
  int total_starts = 0;
  always @(negedge clk) if (rst_n && bus.alu_start) total_starts++;

  logic [7:0] obs_iter[64];
  logic       obs_esc[64];
  int         obs_starts[64];
  int         res_count = 0;
  always @(negedge clk) begin
    if (rst_n && bus.result_valid && bus.result_ready && res_count < 64) begin
      obs_iter[res_count]   = bus.result_iter;
      obs_esc[res_count]    = bus.result_escaped;
      obs_starts[res_count] = total_starts;
      res_count++;
    end
  end

  logic       in_wait    = 1'b0;
  logic       check_zero = 1'b0;
  logic [7:0] h_cr, h_ci, h_zr, h_zi;
  int         stab_err = 0;
  int         zero_err = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_wait = 1'b0;
    end else begin
      if (check_zero && (bus.alu_zr != 8'h00 || bus.alu_zi != 8'h00)) zero_err++;
      if (bus.alu_start) begin
        h_cr = bus.alu_cr; h_ci = bus.alu_ci; h_zr = bus.alu_zr; h_zi = bus.alu_zi;
        in_wait = 1'b1;
      end else if (in_wait) begin
        if (bus.alu_cr != h_cr || bus.alu_ci != h_ci ||
            bus.alu_zr != h_zr || bus.alu_zi != h_zi) stab_err++;
        if (bus.alu_finished) in_wait = 1'b0;
      end
    end
  end

  // ---------------- scoreboard and helpers ----------------
  typedef struct {
    logic [7:0] iter;
    logic       esc;
    int         base;
  } exp_t;
  exp_t sb[$];
  int   rd = 0;

  typedef struct {
    logic [7:0] cr;
    logic [7:0] ci;
    logic [7:0] mi;
    int         lat;
    logic [7:0] e_iter;
    logic       e_esc;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c_r, input logic [7:0] c_i,
                      input logic [7:0] m, input logic [7:0] e_iter,
                      input logic e_esc, input bit track);
    int n = 0;
    while (!bus.pixel_ready && n < 3000) begin tick(); n++; end
    if (!bus.pixel_ready) chk("pixel_ready_timeout", 0, 1);
    bus.pixel_valid = 1'b1;
    bus.cr          = c_r;
    bus.ci          = c_i;
    bus.max_iter    = m;
    if (track) sb.push_back('{e_iter, e_esc, total_starts});
    tick();
    bus.pixel_valid = 1'b0;
  endtask

  task automatic get_result();
    int n = 0;
    exp_t e;
    while (res_count <= rd && n < 3000) begin tick(); n++; end
    if (res_count <= rd) begin
      chk("result_timeout", 0, 1);
      if (sb.size() != 0) e = sb.pop_front();
    end else if (sb.size() == 0) begin
      chk("scoreboard_underflow", 1, 0);
      rd++;
    end else begin
      e = sb.pop_front();
      chk("result_iter", int'(obs_iter[rd]), int'(e.iter));
      chk("result_escaped", int'(obs_esc[rd]), int'(e.esc));
      chk("start_pulses", obs_starts[rd] - e.base,
          e.esc ? int'(e.iter) + 1 : int'(e.iter));
      rd++;
    end
  endtask

  initial begin
    int n;
    // point, limit, ALU latency, expected count, expected escaped
    tbl[0] = '{8'h00, 8'h00, 8'd16, 2, 8'd16, 1'b0}; // origin, never escapes
    tbl[1] = '{8'h7F, 8'h00, 8'd16, 1, 8'd1,  1'b1}; // step 1 overflows
    tbl[2] = '{8'h00, 8'h00, 8'd0,  1, 8'd0,  1'b0}; // zero limit
    tbl[3] = '{8'h40, 8'h00, 8'd16, 3, 8'd1,  1'b1}; // c=1: z2=2.0 overflows
    tbl[4] = '{8'hC0, 8'h00, 8'd10, 1, 8'd10, 1'b0}; // c=-1: period-2 cycle
    tbl[5] = '{8'h20, 8'h00, 8'd8,  2, 8'd4,  1'b1}; // c=0.5: z5 overflows
    tbl[6] = '{8'h00, 8'h40, 8'd12, 4, 8'd12, 1'b0}; // c=i: bounded cycle
    tbl[7] = '{8'h00, 8'h00, 8'd1,  1, 8'd1,  1'b0}; // limit 1
    tbl[8] = '{8'h7F, 8'h00, 8'd1,  1, 8'd1,  1'b0}; // limit 1 before escape

    bus.pixel_valid  = 1'b0;
    bus.cr           = '0;
    bus.ci           = '0;
    bus.max_iter     = '0;
    bus.result_ready = 1'b1;

    // reset values
    repeat (3) tick();
    chk("rst_pixel_ready", int'(bus.pixel_ready), 1);
    chk("rst_result_valid", int'(bus.result_valid), 0);
    chk("rst_alu_start", int'(bus.alu_start), 0);
    chk("rst_result_iter", int'(bus.result_iter), 0);
    chk("rst_result_escaped", int'(bus.result_escaped), 0);
    chk("rst_alu_cr", int'(bus.alu_cr), 0);
    chk("rst_alu_zr", int'(bus.alu_zr), 0);
    rst_n = 1'b1;
    tick();

    // table-driven points
    for (int i = 0; i < 9; i++) begin
      lat        = tbl[i].lat;
      check_zero = (i == 0);
      send(tbl[i].cr, tbl[i].ci, tbl[i].mi, tbl[i].e_iter, tbl[i].e_esc, 1'b1);
      if (tbl[i].mi == 8'd0) begin
        chk("zero_limit_valid", int'(bus.result_valid), 1);
        chk("zero_limit_start", int'(bus.alu_start), 0);
      end
      get_result();
      check_zero = 1'b0;
    end
    chk("origin_z_nonzero_cycles", zero_err, 0);

    // reset in the middle of WAIT
    lat = 5;
    send(8'h20, 8'h00, 8'd16, 8'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("mid_wait_alu_cr", int'(bus.alu_cr), 8'h20);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pixel_ready", int'(bus.pixel_ready), 1);
    chk("mid_rst_result_valid", int'(bus.result_valid), 0);
    chk("mid_rst_alu_start", int'(bus.alu_start), 0);
    chk("mid_rst_alu_cr", int'(bus.alu_cr), 0);
    chk("mid_rst_result_iter", int'(bus.result_iter), 0);
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h20, 8'h00, 8'd8, 8'd4, 1'b1, 1'b1);
    get_result();

    // backpressure with stray pixel_valid traffic
    lat              = 5;
    bus.result_ready = 1'b0;
    send(8'h20, 8'h00, 8'd8, 8'd4, 1'b1, 1'b1);
    n = 0;
    while (!bus.result_valid && n < 3000) begin
      bus.pixel_valid = ~bus.pixel_valid;
      bus.cr          = 8'($urandom);
      bus.ci          = 8'($urandom);
      bus.max_iter    = 8'($urandom);
      tick();
      n++;
    end
    if (!bus.result_valid) chk("bp_valid_timeout", 0, 1);
    for (int k = 0; k < 10; k++) begin
      bus.pixel_valid = (k % 2 == 0);
      bus.cr          = 8'h55;
      bus.ci          = 8'h66;
      bus.max_iter    = 8'd3;
      tick();
      chk("bp_result_valid", int'(bus.result_valid), 1);
      chk("bp_result_iter", int'(bus.result_iter), 4);
      chk("bp_result_escaped", int'(bus.result_escaped), 1);
      chk("bp_pixel_ready", int'(bus.pixel_ready), 0);
    end
    bus.pixel_valid  = 1'b0;
    bus.result_ready = 1'b1;
    tick();
    chk("bp_release_valid", int'(bus.result_valid), 0);
    chk("bp_release_ready", int'(bus.pixel_ready), 1);
    chk("bp_no_stray_latch", int'(bus.alu_cr), 8'h20);
    get_result();
    send(8'h00, 8'h00, 8'd2, 8'd2, 1'b0, 1'b1);
    chk("single_idle_cycle", int'(bus.pixel_ready), 0);
    get_result();

    // limit edge: 255 steps, ALU never escapes
    lat       = 1;
    never_esc = 1'b1;
    send(8'h7F, 8'h00, 8'd255, 8'd255, 1'b0, 1'b1);
    get_result();
    never_esc = 1'b0;

    chk("alu_operand_stability_errors", stab_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
